dm_load_writeback: RTL
======================

DM_LOAD_WRITEBACK -- requirements
Module: dm_load_writeback

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of data memory read data and register write data.
REQ-002 SHALL have parameter ADDR_W, default 16: data memory address width.
REQ-003 SHALL have parameter TIMEOUT, default 15: maximum number of WAIT cycles before abort (used only with the configuration macro).
REQ-004 SHALL have port clk  input  1: single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have port LOAD  input  1: load request, sampled each cycle.
REQ-007 SHALL have ports X_select, Y_select, ACC_select, PC_select  input  1 each: destination register select.
REQ-008 SHALL have port addr  input  ADDR_W: data memory address for the load.
REQ-009 SHALL have port dm_re  output  1: data memory read strobe.
REQ-010 SHALL have port dm_addr  output  ADDR_W: data memory read address.
REQ-011 SHALL have port dm_rdata  input  DATA_W: data memory read data.
REQ-012 SHALL have port dm_valid  input  1: dm_rdata valid strobe.
REQ-013 SHALL have port out_data  output  DATA_W: write-back data to registers.
REQ-014 SHALL have ports X_we, Y_we, ACC_we, PC_we  output  1 each: one-hot register write enables.
REQ-015 SHALL have ports busy, done, err  output  1 each: transfer in progress, write-back pulse, and timeout flag.

Function
REQ-016 SHALL implement the FSM states IDLE, REQ, WAIT and WB.
REQ-017 In IDLE, LOAD=1 with at least one select high SHALL latch addr and a one-hot destination (priority X > Y > ACC > PC), then go to REQ.
REQ-018 LOAD with no select high, or LOAD in any state other than IDLE, SHALL be ignored.
REQ-019 In REQ, the block SHALL drive dm_re=1 for exactly one cycle with dm_addr equal to the latched address, then go to WAIT.
REQ-020 In WAIT, dm_valid=1 SHALL capture dm_rdata into out_data and go to WB.
REQ-021 dm_valid SHALL be ignored in IDLE, REQ and WB.
REQ-022 In WB, the block SHALL assert the latched destination's _we and done for exactly one cycle, then go to IDLE.
REQ-023 busy SHALL be 1 in REQ, WAIT and WB, and 0 in IDLE.
REQ-024 Minimum latency SHALL be 3 cycles: LOAD accepted at cycle N, dm_re at N+1, dm_valid earliest at N+2, write-back at N+3.
REQ-025 out_data SHALL hold its last captured value until the next capture.
REQ-026 At most one _we SHALL be high in any cycle, and only in WB.
REQ-027 dm_addr SHALL be 0 whenever dm_re=0.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL enter IDLE and clear to 0: dm_re, dm_addr, out_data, all _we, busy, done, err, and the latched destination and address.
REQ-029 rst asserted mid-transfer SHALL abort the transfer with no _we asserted; a dm_valid arriving after reset SHALL be ignored.

Configuration
REQ-030 With macro DM_LOAD_TIMEOUT_EN defined, a counter SHALL count WAIT cycles and clear on WAIT entry.
REQ-031 With DM_LOAD_TIMEOUT_EN defined, if TIMEOUT WAIT cycles elapse without dm_valid, the block SHALL return to IDLE with no _we and no done, and set err=1.
REQ-032 With DM_LOAD_TIMEOUT_EN defined, err SHALL stay 1 until the next accepted LOAD or reset.
REQ-033 With DM_LOAD_TIMEOUT_EN undefined, WAIT SHALL persist until dm_valid, err SHALL be tied 0, and no counter SHALL be synthesized.

Verification
REQ-034 The bench SHALL cover: LOAD + ACC_select with addr=0x0010 and dm_valid one cycle after dm_re with dm_rdata=0xBEEF -> dm_re at N+1 with dm_addr=0x0010; ACC_we and done at N+3; out_data=0xBEEF.
REQ-035 The bench SHALL cover: LOAD with X_select and PC_select both high, dm_rdata=0x1234 -> only X_we pulses.
REQ-036 The bench SHALL cover: a second LOAD during WAIT with a different address -> ignored; a single dm_re; the first destination is written.
REQ-037 The bench SHALL cover: rst during WAIT, then dm_valid=1 -> no _we; busy=0; out_data=0.
REQ-038 The bench SHALL cover, with DM_LOAD_TIMEOUT_EN defined: no dm_valid for 15 WAIT cycles -> return to IDLE with err=1 and no _we; the next accepted LOAD clears err.
REQ-039 The bench SHALL cover: LOAD with no select high -> dm_re stays 0 and busy stays 0.

Source files
------------

// File: rtl/dm_load_writeback.sv
// dm_load_writeback: data-memory load with one-hot register write-back; DM_LOAD_TIMEOUT_EN enables the WAIT timeout
module dm_load_writeback #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              LOAD,
    input  logic              X_select,
    input  logic              Y_select,
    input  logic              ACC_select,
    input  logic              PC_select,
    input  logic [ADDR_W-1:0] addr,
    output logic              dm_re,
    output logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              X_we,
    output logic              Y_we,
    output logic              ACC_we,
    output logic              PC_we,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          dst_q, dst_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                accept;
`ifdef DM_LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif
    // next-state: accept a load in IDLE, strobe the read, wait for data, write back
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dst_d   = dst_q;
        data_d  = data_q;
        accept  = LOAD && (X_select || Y_select || ACC_select || PC_select);
`ifdef DM_LOAD_TIMEOUT_EN
        err_d   = err_q;
        cnt_d   = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
`endif
        unique case (state_q)
            IDLE: if (accept) begin
                addr_d  = addr;
                dst_d   = X_select ? 4'b0001 : Y_select ? 4'b0010 : ACC_select ? 4'b0100 : 4'b1000;
                state_d = REQ;
`ifdef DM_LOAD_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            REQ:  state_d = WAIT;
            WAIT: if (dm_valid) begin
                data_d  = dm_rdata;
                state_d = WB;
            end
`ifdef DM_LOAD_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
`endif
            WB:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            dst_q   <= '0;
            data_q  <= '0;
`ifdef DM_LOAD_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
`ifdef DM_LOAD_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end
`ifdef DM_LOAD_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
    assign dm_re    = (state_q == REQ);
    assign dm_addr  = dm_re ? addr_q : '0;
    assign out_data = data_q;
    assign done     = (state_q == WB);
    assign busy     = (state_q != IDLE);
    assign {PC_we, ACC_we, Y_we, X_we} = done ? dst_q : 4'b0000;
endmodule
